// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - ALU execute stage with valid/ready handshake and iterative shifter
// Define ALU_FAST_SHIFT_EN to replace the 1-bit/cycle shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                accept;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     alu_res;
    logic                alu_ill;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid & in_ready;
    assign shamt     = op_b[SHAMT_W-1:0];

`ifndef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]          sel_q, sel_d;
    logic                is_shift;

    assign is_shift = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);

    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [3:0] sel);
        if (sel == ALU_SLL)      return {v[XLEN-2:0], 1'b0};
        else if (sel == ALU_SRL) return {1'b0, v[XLEN-1:1]};
        else                     return {v[XLEN-1], v[XLEN-1:1]};
    endfunction
`endif

    // Iterative build: shift codes yield op_a here, which is both the shamt==0 answer and the shifter seed.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_sel)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
        cnt_d     = cnt_q;
        sel_d     = sel_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    result_d  = alu_res;
                    zero_d    = (alu_res == '0);
                    illegal_d = alu_ill;
                    state_d   = DONE;
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        cnt_d   = shamt;
                        sel_d   = alu_sel;
                        state_d = SHIFT;
                    end
`endif
                end
            end
            SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
                result_d = shift1(result_q, sel_q);
                zero_d   = (shift1(result_q, sel_q) == '0);
                cnt_d    = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            cnt_q     <= '0;
            sel_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - self-checking bench for alu_seq_exec against a behavioural model
module tb_alu_seq_exec;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    localparam logic [3:0] XOR_ = 4'd5, SRL = 4'd6, SRA = 4'd7, OR_ = 4'd8, AND_ = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b, result;
    logic        zero, illegal, busy;

    int          n_checks = 0;
    int          n_pass = 0;
    logic        exp_armed = 1'b0;
    logic [31:0] exp_res;
    logic        exp_zero, exp_ill;

    always #5 clk = ~clk;

    alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
    endtask

    function automatic logic [31:0] model_res(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b % 32);
        case (sel)
            ADD:  return a + b;
            SUB:  return a - b;
            SLL:  return a << s;
            SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            XOR_: return a ^ b;
            SRL:  return a >> s;
            SRA:  return 32'($signed(a) >>> s);
            OR_:  return a | b;
            AND_: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] sel, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((sel == SLL || sel == SRL || sel == SRA) && (b % 32) != 0) return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    // Checks every cycle a result is presented against the armed expectation.
    always @(negedge clk) begin
        if (rst_n && exp_armed && out_valid) begin
            chk("mon_result", result, exp_res);
            chk("mon_zero", 32'(zero), 32'(exp_zero));
            chk("mon_illegal", 32'(illegal), 32'(exp_ill));
            chk("mon_busy", 32'(busy), 32'd1);
        end
    end

    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic lit, input logic [31:0] lres, input logic lzero, input logic lill,
                          input int llat);
        int lat;
        int guard;
        int mlat;
        logic [31:0] mres;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        mres = model_res(sel, a, b);
        mlat = model_lat(sel, b);
        if (lit) begin
            exp_res = lres; exp_zero = lzero; exp_ill = lill; mlat = llat;
        end else begin
            exp_res = mres; exp_zero = (mres == 32'd0); exp_ill = (sel > 4'd9);
        end
        in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        exp_armed = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        alu_sel = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(mlat));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_armed = 1'b0;
        @(negedge clk);
        chk("consumed_out_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int fast;
`ifdef ALU_FAST_SHIFT_EN
        fast = 1;
`else
        fast = 0;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_sel = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op(ADD, 32'hFFFF_FFFF, 32'h1, 0, 1'b1, 32'h0, 1'b1, 1'b0, 1);
        run_op(SUB, 32'd5, 32'd7, 1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run_op(SLT, 32'hFFFF_FFFF, 32'h1, 0, 1'b1, 32'h1, 1'b0, 1'b0, 1);
        run_op(SLTU, 32'hFFFF_FFFF, 32'h1, 0, 1'b1, 32'h0, 1'b1, 1'b0, 1);
        run_op(SRA, 32'h8000_0000, 32'h24, 0, 1'b1, 32'hF800_0000, 1'b0, 1'b0, fast ? 1 : 5);
        run_op(SRL, 32'h8000_0000, 32'h24, 0, 1'b1, 32'h0800_0000, 1'b0, 1'b0, fast ? 1 : 5);
        run_op(SLL, 32'h1, 32'd31, 0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, fast ? 1 : 32);
        run_op(SLL, 32'h1234_5678, 32'h20, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1);
        run_op(SRA, 32'h0000_00F0, 32'h4, 3, 1'b1, 32'h0000_000F, 1'b0, 1'b0, fast ? 1 : 5);
        run_op(4'd12, 32'h55, 32'hAA, 1, 1'b1, 32'h0, 1'b1, 1'b1, 1);

        // reset while shifting
        @(negedge clk);
        in_valid = 1'b1; alu_sel = SLL; op_a = 32'h1; op_b = 32'd31;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), fast ? 32'd1 : 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(ADD, 32'd2, 32'd3, 0, 1'b1, 32'h5, 1'b0, 1'b0, 1);

        // reset while a result is waiting
        @(negedge clk);
        in_valid = 1'b1; alu_sel = ADD; op_a = 32'hFFFF_FFFF; op_b = 32'h1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_zero", 32'(zero), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("done_rst_out_valid", 32'(out_valid), 32'd0);
        chk("done_rst_zero", 32'(zero), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [3:0]  s;
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h8000_0000;
                2: a = b;
                default: ;
            endcase
            run_op(s, a, b, int'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
